// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read
// ports, one rising-edge write port and a word-per-cycle bulk-clear engine.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
// Default build (REGFILE_BYPASS_EN undefined) reads stored contents only.
module regfile_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic                 RegWrite,
    input  logic                 Clear,
    output logic                 Busy,
    output logic                 WriteDropped
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Sweep start: word 0 is skipped when it is hardwired to zero.
    localparam logic [ADDR_BITS:0] FIRST = (ADDR_BITS+1)'((ZERO_REG != 0) ? 1 : 0);
    // Counter is one bit wider than an address so the last word is
    // recognised without the counter wrapping back to zero.
    localparam logic [ADDR_BITS:0] LAST  = (ADDR_BITS+1)'(DEPTH - 1);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_CLEARING = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS:0]   r_cnt;
    logic                 r_busy;
    logic                 r_drop;

    // Flattened view of every stored word, used by the read muxes.
    logic [DEPTH-1:0][WIDTH-1:0] w_words;

    logic w_wr_zero;   // write aimed at the hardwired zero word
    logic w_wr_req;    // a write that would really change a word
    logic w_wr_ok;     // that write is accepted this edge
    logic w_sweep;     // clear engine zeroes r_cnt this edge

    assign w_wr_zero = (ZERO_REG != 0) && (WriteRegister == '0);
    assign w_wr_req  = RegWrite && !w_wr_zero;
    assign w_wr_ok   = w_wr_req && !r_busy;
    assign w_sweep   = (r_state == S_CLEARING);

    // Clear engine FSM plus the registered Busy / WriteDropped outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            // A write refused because the sweep owns the array; discarded
            // writes to the zero word never count as refused.
            r_drop <= w_wr_req && r_busy;
            case (r_state)
                S_IDLE: begin
                    if (Clear) begin
                        r_state <= S_CLEARING;
                        r_cnt   <= FIRST;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEARING: begin
                    // Clear requests are ignored here: no restart mid-sweep.
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One storage word per address; the sweep and the write port never
    // collide because writes are refused while the sweep runs.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_hardwired
                assign w_words[gi] = '0;
            end else begin : g_storage
                logic [WIDTH-1:0] r_word;
                logic             w_hit_sweep;
                logic             w_hit_write;

                assign w_hit_sweep = w_sweep && (r_cnt[ADDR_BITS-1:0] == ADDR_BITS'(gi));
                assign w_hit_write = w_wr_ok && (WriteRegister == ADDR_BITS'(gi));

                // Hold, sweep-to-zero, or load from the write port.
                always_ff @(posedge Clk or posedge Reset) begin
                    if (Reset) begin
                        r_word <= '0;
                    end else if (w_hit_sweep) begin
                        r_word <= '0;
                    end else if (w_hit_write) begin
                        r_word <= WriteData;
                    end
                end

                assign w_words[gi] = r_word;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of an accepted write to a matching read port.
    logic w_byp1;
    logic w_byp2;
    assign w_byp1    = w_wr_ok && (ReadRegister1 == WriteRegister);
    assign w_byp2    = w_wr_ok && (ReadRegister2 == WriteRegister);
    assign ReadData1 = w_byp1 ? WriteData : w_words[ReadRegister1];
    assign ReadData2 = w_byp2 ? WriteData : w_words[ReadRegister2];
`else
    // Reads show stored contents only.
    assign ReadData1 = w_words[ReadRegister1];
    assign ReadData2 = w_words[ReadRegister2];
`endif

    assign Busy         = r_busy;
    assign WriteDropped = r_drop;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the fixed 32x32 MIPS register file. It provides configurable data width and depth, two asynchronous read ports, and one positive-edge write port. It adds a sequential bulk-clear engine that zeroes the array one word per cycle, with a busy/drop handshake. It sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
WIDTH, 32, data word width in bits
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS words
ZERO_REG, 1, 1 = word 0 is hardwired zero (MIPS $zero); 0 = word 0 is an ordinary register

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
ReadData1  output  WIDTH  contents of word at ReadRegister1
ReadData2  output  WIDTH  contents of word at ReadRegister2
WriteData  input  WIDTH  data to write
ReadRegister1  input  ADDR_BITS  read port 1 address
ReadRegister2  input  ADDR_BITS  read port 2 address
WriteRegister  input  ADDR_BITS  write address
RegWrite  input  1  write enable, sampled on rising Clk
Clear  input  1  bulk-clear request, sampled on rising Clk
Busy  output  1  high while the clear engine is running
WriteDropped  output  1  registered one-cycle pulse: a write was refused because Busy was high

Behaviour:
- Reset (asynchronous, active-high) and clock are as decided: single clock Clk; Reset is asynchronous and active-high.
- On Reset assertion: all words = 0; FSM = IDLE; clear counter = 0; Busy = 0; WriteDropped = 0. Effect is immediate, independent of Clk.
- Reads: purely combinational. ReadDataN = mem[ReadRegisterN].
- If ZERO_REG=1: a read of address 0 always returns 0, and writes to address 0 are silently discarded. Such a write is not counted as dropped.
- Write: at a rising edge with RegWrite=1 and Busy=0, mem[WriteRegister] <= WriteData. The new value is visible on the read ports after that edge (no same-cycle bypass unless the optional feature is enabled).
- FSM states: IDLE and CLEARING.
  - IDLE -> CLEARING at a rising edge with Clear=1. Counter loads FIRST (1 if ZERO_REG=1, else 0). Busy=1 from that edge.
  - CLEARING: each rising edge zeroes mem[counter] and increments counter.
  - At the edge that zeroes address DEPTH-1, the FSM returns to IDLE and Busy=0. Busy is therefore high for DEPTH-FIRST cycles (31 at defaults).
  - Counter arithmetic is ADDR_BITS+1 wide, so the last address is detected without wrap-around.
- Clear while CLEARING is ignored; the sweep does not restart.
- RegWrite=1 while Busy=1: the write is not performed, and WriteDropped=1 for exactly the following cycle. Consecutive refused writes keep WriteDropped high continuously.
- Clear=1 and RegWrite=1 at the same edge in IDLE: the write completes at that edge. The sweep then starts and will later zero that word.
- Reads during CLEARING return current contents: words already swept read 0, the rest read their old values.
- Reset mid-sweep: all words = 0, FSM = IDLE, Busy = 0 immediately.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port returns WriteData combinationally when all of the following hold:
  - RegWrite=1;
  - Busy=0;
  - ReadRegisterN == WriteRegister;
  - not (ZERO_REG=1 and address 0).
  This gives write-then-read in the same cycle for the pipeline.
- Undefined: read ports always show stored contents, and the written value appears only after the edge. No bypass logic is synthesised.

Test Plan:
1. Reset pulse, then read all addresses on both ports -> every ReadData = 0, Busy=0, WriteDropped=0.
2. Write 32'd88 to addr 10, read ReadRegister1=10 and ReadRegister2=9 -> before edge 0 and 0 (88 on port 1 if REGFILE_BYPASS_EN); after edge 88 and 0.
3. ZERO_REG=1: write 32'hDEADBEEF to addr 0 -> ReadData1 at addr 0 stays 0, WriteDropped stays 0.
4. Fill addrs 1..31 with value addr*3, pulse Clear, write 32'd7 to addr 5 during the sweep -> Busy high exactly 31 cycles; WriteDropped pulses one cycle; all words read 0 afterwards.
5. Start Clear, assert Reset after 10 cycles -> Busy drops immediately, all words 0, and a write of 32'd55 to addr 3 on the next edge is accepted.
6. Clear and write 32'd99 to addr 31 at the same edge -> addr 31 reads 99 until the sweep reaches it, then 0; Busy deasserts on that edge.
